// File: rtl/mem_handshake_ctrl.sv
// mem_handshake_ctrl: byte-addressed big-endian RAM behind an MFA/MFC
// four-phase handshake, with a programmable number of wait states.
//
// Ports
//   clk          rising-edge clock
//   clr          asynchronous active-low reset
//   mfa          memory function asserted (request, held until mfc seen)
//   rw           0 = read, 1 = write
//   mas          access size: 00 byte, 01 word, 10 halfword, 11 reserved
//   addr         byte address (MAR)
//   wdata        write data (MDR), byte/halfword use the low bits
//   rdata        read data, zero-extended for byte/halfword
//   mfc          memory function complete
//   align_fault  misaligned or reserved-size access in this transaction
//   busy         controller is not idle
module mem_handshake_ctrl #(
   parameter int unsigned ADDR_W      = 9,
   parameter int unsigned WAIT_CYCLES = 2,
   parameter int unsigned CNT_W       = 4
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              mfa,
   input  logic              rw,
   input  logic [1:0]        mas,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata,
   output logic              mfc,
   output logic              align_fault,
   output logic              busy
);

   localparam int unsigned DEPTH  = 1 << ADDR_W;
   localparam int unsigned DATA_W = 32;

   localparam logic [1:0] MAS_BYTE = 2'b00;
   localparam logic [1:0] MAS_WORD = 2'b01;
   localparam logic [1:0] MAS_HALF = 2'b10;

   localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES);
   localparam bit               HAS_WAIT  = (WAIT_CYCLES != 0);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      ACCESS = 2'd2,
      DONE   = 2'd3
   } state_e;

   logic [7:0]        mem_q [DEPTH];

   state_e            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [ADDR_W-1:0] addr_q;
   logic              rw_q;
   logic [1:0]        mas_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rdata_q;
   logic              mfc_q;
   logic              fault_q;
   logic              busy_q;

   logic [ADDR_W-1:0] ea_c;
   logic [ADDR_W-1:0] a1_c;
   logic [ADDR_W-1:0] a2_c;
   logic [ADDR_W-1:0] a3_c;
   logic              fault_c;
   logic [DATA_W-1:0] rd_c;

   // Effective (aligned) address, fault detection and big-endian read lanes
   always_comb begin
      ea_c    = addr_q;
      fault_c = 1'b0;
      case (mas_q)
         MAS_BYTE: begin
            ea_c    = addr_q;
            fault_c = 1'b0;
         end
         MAS_HALF: begin
            ea_c    = {addr_q[ADDR_W-1:1], 1'b0};
            fault_c = addr_q[0];
         end
         MAS_WORD: begin
            ea_c    = {addr_q[ADDR_W-1:2], 2'b00};
            fault_c = |addr_q[1:0];
         end
         default: begin
            // reserved size: performed as a word access, always flagged
            ea_c    = {addr_q[ADDR_W-1:2], 2'b00};
            fault_c = 1'b1;
         end
      endcase

      // lane addresses wrap modulo the array size
      a1_c = ea_c + ADDR_W'(1);
      a2_c = ea_c + ADDR_W'(2);
      a3_c = ea_c + ADDR_W'(3);

      case (mas_q)
         MAS_BYTE: rd_c = {24'h000000, mem_q[ea_c]};
         MAS_HALF: rd_c = {16'h0000, mem_q[ea_c], mem_q[a1_c]};
         default:  rd_c = {mem_q[ea_c], mem_q[a1_c], mem_q[a2_c], mem_q[a3_c]};
      endcase
   end

   // Array write port: only the selected bytes change, on the ACCESS edge
   always_ff @(posedge clk) begin
      if (state_q == ACCESS && rw_q) begin
         case (mas_q)
            MAS_BYTE: begin
               mem_q[ea_c] <= wdata_q[7:0];
            end
            MAS_HALF: begin
               mem_q[ea_c] <= wdata_q[15:8];
               mem_q[a1_c] <= wdata_q[7:0];
            end
            default: begin
               mem_q[ea_c] <= wdata_q[31:24];
               mem_q[a1_c] <= wdata_q[23:16];
               mem_q[a2_c] <= wdata_q[15:8];
               mem_q[a3_c] <= wdata_q[7:0];
            end
         endcase
      end
   end

   // Handshake FSM with registered outputs
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         rw_q    <= 1'b0;
         mas_q   <= 2'b00;
         wdata_q <= '0;
         rdata_q <= '0;
         mfc_q   <= 1'b0;
         fault_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (mfa) begin
                  addr_q  <= addr;
                  rw_q    <= rw;
                  mas_q   <= mas;
                  wdata_q <= wdata;
                  busy_q  <= 1'b1;
                  if (HAS_WAIT) begin
                     state_q <= WAIT;
                     cnt_q   <= WAIT_LOAD;
                  end else begin
                     state_q <= ACCESS;
                  end
               end
            end
            WAIT: begin
               // withdrawn request aborts before anything is touched
               if (!mfa) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
                  busy_q  <= 1'b0;
               end else if (cnt_q == CNT_W'(1)) begin
                  state_q <= ACCESS;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            ACCESS: begin
               fault_q <= fault_c;
               if (!rw_q) begin
                  rdata_q <= rd_c;
               end
               state_q <= DONE;
            end
            DONE: begin
               // mfc follows mfa until the requester releases it
               if (mfa) begin
                  mfc_q <= 1'b1;
               end else begin
                  mfc_q   <= 1'b0;
                  fault_q <= 1'b0;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
               cnt_q   <= '0;
               mfc_q   <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign rdata       = rdata_q;
   assign mfc         = mfc_q;
   assign align_fault = fault_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_mem_handshake_ctrl.sv
// Directed bench for mem_handshake_ctrl: one instance with two wait states,
// one with none. Expected results are queued when a request is issued and
// compared when mfc rises.
module tb_mem_handshake_ctrl;

   logic        clk = 1'b0;
   logic        clr;
   logic        mfa;
   logic        rw;
   logic [1:0]  mas;
   logic [8:0]  addr;
   logic [31:0] wdata;
   logic        sel;   // 0 = WAIT_CYCLES 2 instance, 1 = WAIT_CYCLES 0 instance

   logic [31:0] rdata2, rdata0;
   logic        mfc2, mfc0, fault2, fault0, busy2, busy0;
   logic        mfa2, mfa0;
   logic [31:0] rdata_m;
   logic        mfc_m, fault_m, busy_m;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [31:0] rdata;
      logic        fault;
   } exp_t;
   exp_t sb_q[$];

   always #5 clk = ~clk;

   assign mfa2    = mfa & ~sel;
   assign mfa0    = mfa & sel;
   assign rdata_m = sel ? rdata0 : rdata2;
   assign mfc_m   = sel ? mfc0   : mfc2;
   assign fault_m = sel ? fault0 : fault2;
   assign busy_m  = sel ? busy0  : busy2;

   mem_handshake_ctrl #(.ADDR_W(9), .WAIT_CYCLES(2), .CNT_W(4)) dut2 (
      .clk(clk), .clr(clr), .mfa(mfa2), .rw(rw), .mas(mas), .addr(addr),
      .wdata(wdata), .rdata(rdata2), .mfc(mfc2), .align_fault(fault2), .busy(busy2)
   );

   mem_handshake_ctrl #(.ADDR_W(9), .WAIT_CYCLES(0), .CNT_W(4)) dut0 (
      .clk(clk), .clr(clr), .mfa(mfa0), .rw(rw), .mas(mas), .addr(addr),
      .wdata(wdata), .rdata(rdata0), .mfc(mfc0), .align_fault(fault0), .busy(busy0)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Full handshake; inputs are scrambled after the request edge to prove latching
   task automatic txn(input string tag, input logic w, input logic [1:0] m,
                      input logic [8:0] a, input logic [31:0] d,
                      input logic [31:0] exp_rd, input logic exp_f, input int exp_lat);
      exp_t e;
      int   cyc;
      e.rdata = exp_rd;
      e.fault = exp_f;
      sb_q.push_back(e);
      rw = w; mas = m; addr = a; wdata = d; mfa = 1'b1;
      @(posedge clk); #1;
      rw = ~w; mas = ~m; addr = ~a; wdata = ~d;
      cyc = 0;
      while (!mfc_m && cyc < 50) begin
         @(posedge clk); #1;
         cyc++;
      end
      check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
      e = sb_q.pop_front();
      check({tag, "_rdata"}, rdata_m, e.rdata);
      check({tag, "_fault"}, 32'(fault_m), 32'(e.fault));
      check({tag, "_busy"}, 32'(busy_m), 32'd1);
      repeat (2) begin
         @(posedge clk); #1;
         check({tag, "_mfc_hold"}, 32'(mfc_m), 32'd1);
      end
      mfa = 1'b0;
      @(posedge clk); #1;
      check({tag, "_mfc_release"}, 32'(mfc_m), 32'd0);
      check({tag, "_busy_release"}, 32'(busy_m), 32'd0);
      check({tag, "_fault_clear"}, 32'(fault_m), 32'd0);
   endtask

   initial begin
      clr = 1'b0; mfa = 1'b0; rw = 1'b0; mas = 2'b00; addr = '0; wdata = '0; sel = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_mfc2",   32'(mfc2),   32'd0);
      check("rst_rdata2", rdata2,      32'd0);
      check("rst_fault2", 32'(fault2), 32'd0);
      check("rst_busy2",  32'(busy2),  32'd0);
      check("rst_mfc0",   32'(mfc0),   32'd0);
      check("rst_rdata0", rdata0,      32'd0);
      clr = 1'b1;
      @(posedge clk); #1;

      // two wait states
      txn("wr_word",   1'b1, 2'b01, 9'h010, 32'h12345678, 32'h00000000, 1'b0, 4);
      txn("rd_byte",   1'b0, 2'b00, 9'h011, 32'h0,        32'h00000034, 1'b0, 4);
      txn("rd_half",   1'b0, 2'b10, 9'h012, 32'h0,        32'h00005678, 1'b0, 4);
      txn("wr_byte",   1'b1, 2'b00, 9'h013, 32'hFFFFFFAB, 32'h00005678, 1'b0, 4);
      txn("rd_word",   1'b0, 2'b01, 9'h010, 32'h0,        32'h123456AB, 1'b0, 4);
      txn("rd_misal",  1'b0, 2'b01, 9'h012, 32'h0,        32'h123456AB, 1'b1, 4);
      txn("rd_rsvd",   1'b0, 2'b11, 9'h010, 32'h0,        32'h123456AB, 1'b1, 4);
      txn("wr_half_m", 1'b1, 2'b10, 9'h013, 32'h0000BEEF, 32'h123456AB, 1'b1, 4);
      txn("rd_after_h",1'b0, 2'b01, 9'h010, 32'h0,        32'h1234BEEF, 1'b0, 4);
      txn("wr_020",    1'b1, 2'b01, 9'h020, 32'hCAFEF00D, 32'h1234BEEF, 1'b0, 4);

      // request withdrawn during WAIT
      rw = 1'b1; mas = 2'b01; addr = 9'h020; wdata = 32'h11111111; mfa = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("abort_busy_wait", 32'(busy2), 32'd1);
      mfa = 1'b0;
      @(posedge clk); #1;
      check("abort_busy_idle", 32'(busy2), 32'd0);
      repeat (4) begin
         @(posedge clk); #1;
         check("abort_no_mfc", 32'(mfc2), 32'd0);
      end
      txn("rd_020_abort", 1'b0, 2'b01, 9'h020, 32'h0, 32'hCAFEF00D, 1'b0, 4);

      // reset pulse during WAIT
      rw = 1'b1; mas = 2'b01; addr = 9'h020; wdata = 32'h22222222; mfa = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      clr = 1'b0;
      #1;
      check("clr_mfc",   32'(mfc2),  32'd0);
      check("clr_busy",  32'(busy2), 32'd0);
      check("clr_rdata", rdata2,     32'd0);
      mfa = 1'b0;
      @(posedge clk); #1;
      clr = 1'b1;
      @(posedge clk); #1;
      txn("rd_020_clr", 1'b0, 2'b01, 9'h020, 32'h0, 32'hCAFEF00D, 1'b0, 4);

      // zero wait states, back-to-back transactions
      sel = 1'b1;
      txn("z_wr",    1'b1, 2'b01, 9'h100, 32'hA5A55A5A, 32'h00000000, 1'b0, 2);
      txn("z_rd",    1'b0, 2'b01, 9'h100, 32'h0,        32'hA5A55A5A, 1'b0, 2);
      txn("z_rdb",   1'b0, 2'b00, 9'h101, 32'h0,        32'h000000A5, 1'b0, 2);
      txn("z_rdh",   1'b0, 2'b10, 9'h102, 32'h0,        32'h00005A5A, 1'b0, 2);

      // mfa released during ACCESS: read completes, DONE exits at once, no mfc
      rw = 1'b0; mas = 2'b00; addr = 9'h103; mfa = 1'b1;
      @(posedge clk); #1;
      mfa = 1'b0;
      @(posedge clk); #1;
      check("acc_drop_rdata", rdata0,      32'h0000005A);
      check("acc_drop_mfc1",  32'(mfc0),   32'd0);
      @(posedge clk); #1;
      check("acc_drop_mfc2",  32'(mfc0),   32'd0);
      check("acc_drop_busy",  32'(busy0),  32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_handshake_ctrl.md
Name: mem_handshake_ctrl

Overview:
- Byte-addressed RAM with a memory-function handshake, directly downstream of the microprogrammed control unit.
- Consumes the control word's MFA, R/W and MAS fields, plus address and write data from the datapath (MAR/MDR).
- Returns MFC, which the control unit's condition mux samples to leave its wait state, and read data for the MDR.
- Data is big-endian, with programmable wait states.

Parameters:
- ADDR_W, 9: byte-address width; the array holds 2**ADDR_W bytes.
- WAIT_CYCLES, 2: extra wait cycles inserted before the array access (0 to 15).
- CNT_W, 4: width of the wait counter.

Ports:
- clk, in, 1: clock; all state updates on rising edge.
- clr, in, 1: asynchronous active-low reset.
- mfa, in, 1: memory function asserted, from control word bit MFA.
- rw, in, 1: 0 = read, 1 = write; from control word bit R/W.
- mas, in, 2: access size. 00 = byte, 01 = word, 10 = halfword, 11 = reserved (treated as word, sets fault).
- addr, in, ADDR_W: byte address, from MAR.
- wdata, in, 32: write data, from MDR. Byte/halfword writes use the low bits.
- rdata, out, 32: read data, zero-extended for byte/halfword.
- mfc, out, 1: memory function complete.
- align_fault, out, 1: misaligned or reserved-size access detected in the current transaction.
- busy, out, 1: high whenever the FSM is not in IDLE.

Behaviour:
- Reset (clr low, asynchronous): state IDLE; mfc = 0, rdata = 0, align_fault = 0, busy = 0; wait counter = 0. Array contents are not cleared.
- FSM states: IDLE, WAIT, ACCESS, DONE.
- IDLE:
  - If mfa = 1 at a clock edge, latch addr, rw, mas and wdata.
  - Go to WAIT if WAIT_CYCLES > 0 (counter loaded with WAIT_CYCLES); otherwise go to ACCESS.
  - Latched values are used for the whole transaction; later input changes are ignored.
- WAIT:
  - Counter decrements each cycle; go to ACCESS when the counter reaches 1 (counter clears to 0).
  - If mfa drops while in WAIT, abort to IDLE: no write, rdata unchanged.
- ACCESS, one cycle:
  - The array read or write happens on this edge.
  - The effective address is aligned down: word clears addr[1:0], halfword clears addr[0].
  - align_fault is set if the dropped bits were nonzero, or if mas = 11.
  - The access still completes at the aligned address.
  - Go to DONE.
- Big-endian byte lanes (A = aligned address):
  - Word: mem[A] goes to bits [31:24], mem[A+3] to bits [7:0].
  - Halfword: mem[A] goes to bits [15:8], mem[A+1] to bits [7:0].
  - Byte: mem[addr] goes to bits [7:0].
- Writes modify only the selected bytes.
- Reads load rdata at the ACCESS edge, with upper bits zeroed.
- Writes leave rdata unchanged.
- DONE:
  - mfc = 1, held while mfa = 1 (four-phase handshake).
  - When mfa is sampled 0: go to IDLE, mfc = 0 on that same edge, align_fault cleared.
- Latency: mfa sampled high at edge N gives mfc = 1 after edge N + WAIT_CYCLES + 2.
- Back-to-back transactions: mfa must be seen low for at least one edge between them. A new transaction never starts from DONE.
- Address wrap: A+1..A+3 wrap modulo 2**ADDR_W. In practice this is unreachable after alignment.
- Reset mid-transaction: immediate return to IDLE.
  - A write is committed only if the ACCESS edge already occurred.
  - mfc drops asynchronously with clr.
- mfa falling during ACCESS is ignored; the transaction completes and DONE then immediately exits on the next edge.
- rdata holds its value until the next read ACCESS or reset.

Test Plan:
- Reset, then write word 0x12345678 to addr 0x010 with WAIT_CYCLES = 2 -> mfc rises exactly 4 cycles after mfa is sampled. mem[0x10..0x13] = 12, 34, 56, 78. align_fault = 0.
- Byte read at 0x011, then halfword read at 0x012 -> rdata = 0x00000034, then 0x00005678. Each mfc is held until mfa drops, then clears on the next edge.
- Byte write 0xAB to 0x013, then word read of 0x010 -> rdata = 0x123456AB. The other bytes are untouched.
- Misaligned word read at 0x012 -> align_fault = 1, rdata = 0x123456AB (aligned to 0x010). mas = 11 read -> align_fault = 1, word result.
- Write to 0x020 with mfa dropped during WAIT -> FSM returns to IDLE, mfc is never asserted, a later read of 0x020 returns its pre-write value. Separately, clr pulsed low in WAIT -> mfc = 0, busy = 0, no write.
- WAIT_CYCLES = 0 build: read -> mfc after 2 edges. Back-to-back reads separated by one mfa-low cycle -> two distinct mfc pulses, correct data each.
